// File: rtl/coco_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coco_timer_pkg
// Brief    : Register map, CTRL bit layout, mode codes and FSM encoding
//            shared by the coco_timer countdown timer.
// Revision : 1.0 - initial release
// ============================================================================
package coco_timer_pkg;

  // Word offsets decoded from Addr[3:2]
  localparam logic [1:0] c_off_ctrl   = 2'd0;
  localparam logic [1:0] c_off_preset = 2'd1;
  localparam logic [1:0] c_off_count  = 2'd2;

  // CTRL bit positions
  localparam int unsigned c_bit_en      = 0;
  localparam int unsigned c_bit_mode_lo = 1;
  localparam int unsigned c_bit_mode_hi = 2;
  localparam int unsigned c_bit_im      = 3;

  localparam logic [1:0] c_mode_oneshot = 2'b00;
  localparam logic [1:0] c_mode_reload  = 2'b01;

  typedef enum logic [1:0] {
    c_st_idle = 2'd0,
    c_st_load = 2'd1,
    c_st_cnt  = 2'd2,
    c_st_int  = 2'd3
  } state_t;

  // Unassigned mode codes fold onto one-shot
  function automatic logic [1:0] mode_eff(input logic [1:0] mode);
    return (mode == c_mode_reload) ? c_mode_reload : c_mode_oneshot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coco_timer.sv
`default_nettype none
// ============================================================================
// Module   : coco_timer
// Brief    : Memory-mapped 32-bit countdown timer with one-shot and
//            auto-reload modes and a maskable level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module coco_timer
  import coco_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic [31:0] WData,
  input  logic        WE,
  output logic [31:0] RData,
  output logic        IRQ
);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_ctrl;
  logic [3:0]  w_ctrl_next;
  logic [31:0] r_preset;
  logic [31:0] w_preset_next;
  logic [31:0] r_count;
  logic [31:0] w_count_next;
  logic        r_irq;
  logic        w_irq_next;

  logic [1:0]  w_off;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_en;
  logic [1:0]  w_mode;
  logic        w_irq_set;
  logic        w_irq_clr;
  logic        w_fsm_en_clr;
  logic        w_unused;

  assign w_off       = Addr[3:2];
  assign w_unused    = ^Addr[31:4];
  assign w_wr_ctrl   = WE && (w_off == c_off_ctrl);
  assign w_wr_preset = WE && (w_off == c_off_preset);
  assign w_en        = r_ctrl[c_bit_en];
  assign w_mode      = r_ctrl[c_bit_mode_hi:c_bit_mode_lo];

  always_comb begin
    w_state_next  = r_state;
    w_ctrl_next   = r_ctrl;
    w_preset_next = r_preset;
    w_count_next  = r_count;
    w_irq_next    = r_irq;
    w_irq_set     = 1'b0;
    w_irq_clr     = 1'b0;
    w_fsm_en_clr  = 1'b0;

    case (r_state)
      c_st_idle: begin
        if (w_en) begin
          w_state_next = c_st_load;
          w_irq_clr    = 1'b1;
        end
      end
      c_st_load: begin
        w_count_next = r_preset;
        // A zero preset expires straight from LOAD, keeping the t+3 first
        // expiry and the P+2 reload period consistent for P=0.
        if (r_preset == 32'd0) begin
          w_irq_set    = 1'b1;
          w_state_next = c_st_int;
        end else begin
          w_state_next = c_st_cnt;
        end
      end
      c_st_cnt: begin
        if (!w_en) begin
          w_state_next = c_st_idle;
        end else if (r_count > 32'd1) begin
          w_count_next = r_count - 32'd1;
        end else begin
          w_count_next = 32'd0;
          w_irq_set    = 1'b1;
          w_state_next = c_st_int;
        end
      end
      c_st_int: begin
        if (mode_eff(w_mode) == c_mode_reload) begin
          w_irq_clr    = 1'b1;
          w_state_next = c_st_load;
        end else begin
          w_fsm_en_clr = 1'b1;
          w_state_next = c_st_idle;
        end
      end
      default: w_state_next = c_st_idle;
    endcase

    // CPU writes take priority over the FSM's own EN clear
    if (w_fsm_en_clr) w_ctrl_next[c_bit_en] = 1'b0;
    if (w_wr_ctrl)    w_ctrl_next = WData[3:0];
    if (w_wr_preset)  w_preset_next = WData;

    // A concurrent set beats any clear
    if (w_irq_clr || w_wr_ctrl || w_wr_preset) w_irq_next = 1'b0;
    if (w_irq_set) w_irq_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_st_idle;
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ctrl   <= w_ctrl_next;
      r_preset <= w_preset_next;
      r_count  <= w_count_next;
      r_irq    <= w_irq_next;
    end
  end

  always_comb begin
    RData = 32'd0;
    case (w_off)
      c_off_ctrl:   RData = {28'd0, r_ctrl};
      c_off_preset: RData = r_preset;
      c_off_count:  RData = r_count;
      default:      RData = 32'd0;
    endcase
  end

  assign IRQ = r_irq & r_ctrl[c_bit_im];

endmodule
`default_nettype wire

// File: tb/tb_coco_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_coco_timer
// Brief    : Directed self-checking bench for coco_timer with a queue of
//            expected register/IRQ values drained each sampled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coco_timer;
  import coco_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] Addr;
  logic [31:0] WData;
  logic        WE;
  logic [31:0] RData;
  logic        IRQ;

  coco_timer dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WData (WData),
    .WE    (WE),
    .RData (RData),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          is_irq;
    logic [1:0]  off;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Random upper address bits confirm only Addr[3:2] is decoded
  function automatic logic [29:0] mk_addr(input logic [1:0] off);
    logic [31:0] r;
    r = $urandom;
    return {r[27:0], off};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    Addr  = mk_addr(off);
    WData = d;
    WE    = 1'b1;
    tick();
    WE    = 1'b0;
  endtask

  task automatic exp_rd(input string tag, input logic [1:0] off, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b0; e.off = off; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_irq(input string tag, input logic v);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b1; e.off = 2'd0; e.val = {31'd0, v};
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_irq) begin
        obs = {31'd0, IRQ};
      end else begin
        Addr = mk_addr(e.off);
        #1;
        obs = RData;
      end
      n_total++;
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    reset = 1'b1; WE = 1'b0; Addr = '0; WData = '0;
    tick(3);
    reset = 1'b0;

    exp_irq("rst_irq", 1'b0);
    exp_rd("rst_ctrl",   2'd0, 32'd0);
    exp_rd("rst_preset", 2'd1, 32'd0);
    exp_rd("rst_count",  2'd2, 32'd0);
    exp_rd("rst_offc",   2'd3, 32'd0);
    drain();

    // One-shot, PRESET=5, IM set
    wr(c_off_preset, 32'd5);
    wr(c_off_ctrl, 32'h9);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      exp_rd("os_count", c_off_count, 32'(5 - i));
      exp_irq("os_irq_low", 1'b0);
      drain();
      tick();
    end
    exp_irq("os_irq_rise", 1'b1);
    exp_rd("os_count_zero", c_off_count, 32'd0);
    drain();
    tick();
    exp_rd("os_ctrl_en_clr", c_off_ctrl, 32'h8);
    exp_irq("os_irq_hold", 1'b1);
    drain();
    tick(20);
    exp_irq("os_irq_held20", 1'b1);
    drain();
    wr(c_off_ctrl, 32'h8);
    exp_irq("os_irq_wr_clr", 1'b0);
    drain();

    // Auto-reload, PRESET=3: period 5
    wr(c_off_preset, 32'd3);
    wr(c_off_ctrl, 32'hB);
    tick(2);
    for (int c = 0; c < 15; c++) begin
      p = c % 5;
      exp_rd("ar_count", c_off_count,
             (p == 0) ? 32'd3 : (p == 1) ? 32'd2 : (p == 2) ? 32'd1 : 32'd0);
      exp_irq("ar_irq", p == 3);
      drain();
      tick();
    end
    wr(c_off_ctrl, 32'h0);
    tick(2);

    // Masked expiry, PRESET=10, IM=0
    wr(c_off_preset, 32'd10);
    wr(c_off_ctrl, 32'h1);
    tick(12);
    exp_irq("mask_irq_low", 1'b0);
    exp_rd("mask_count_zero", c_off_count, 32'd0);
    drain();
    tick();
    exp_rd("mask_ctrl_en_clr", c_off_ctrl, 32'h0);
    drain();
    wr(c_off_ctrl, 32'h8);
    exp_irq("mask_unmask_cleared", 1'b0);
    exp_rd("mask_ctrl", c_off_ctrl, 32'h8);
    drain();

    // PRESET=0 expires at t+3
    wr(c_off_preset, 32'd0);
    wr(c_off_ctrl, 32'h9);
    tick();
    exp_irq("p0_irq_t2", 1'b0);
    drain();
    tick();
    exp_irq("p0_irq_t3", 1'b1);
    exp_rd("p0_count", c_off_count, 32'd0);
    drain();
    tick();
    exp_rd("p0_ctrl", c_off_ctrl, 32'h8);
    exp_irq("p0_irq_hold", 1'b1);
    drain();
    wr(c_off_ctrl, 32'h0);
    exp_irq("p0_irq_clr", 1'b0);
    drain();

    // Mid-count PRESET write, disable, re-enable
    wr(c_off_preset, 32'd10);
    wr(c_off_ctrl, 32'h1);
    tick(2);
    exp_rd("mid_count_t3", c_off_count, 32'd10);
    drain();
    tick(3);
    exp_rd("mid_count_7", c_off_count, 32'd7);
    drain();
    wr(c_off_preset, 32'd2);
    exp_rd("mid_count_6", c_off_count, 32'd6);
    drain();
    tick();
    exp_rd("mid_count_5", c_off_count, 32'd5);
    drain();
    wr(c_off_ctrl, 32'h0);
    exp_rd("mid_stop_count", c_off_count, 32'd4);
    drain();
    tick(2);
    exp_rd("mid_frozen", c_off_count, 32'd4);
    exp_rd("mid_preset", c_off_preset, 32'd2);
    drain();
    wr(c_off_ctrl, 32'h1);
    tick(2);
    exp_rd("mid_reload_2", c_off_count, 32'd2);
    drain();
    tick();
    exp_rd("mid_reload_1", c_off_count, 32'd1);
    drain();
    tick();
    exp_rd("mid_reload_0", c_off_count, 32'd0);
    exp_irq("mid_masked", 1'b0);
    drain();
    tick(2);

    // Reset mid-count with a concurrent CTRL write
    wr(c_off_preset, 32'd20);
    wr(c_off_ctrl, 32'h9);
    tick(4);
    exp_rd("rc_count_18", c_off_count, 32'd18);
    drain();
    reset = 1'b1;
    Addr  = mk_addr(c_off_ctrl);
    WData = 32'hF;
    WE    = 1'b1;
    tick();
    reset = 1'b0;
    WE    = 1'b0;
    exp_irq("rc_irq", 1'b0);
    exp_rd("rc_ctrl",   c_off_ctrl,   32'd0);
    exp_rd("rc_preset", c_off_preset, 32'd0);
    exp_rd("rc_count",  c_off_count,  32'd0);
    drain();
    wr(c_off_count, 32'h1234);
    wr(2'd3, 32'hFFFF);
    tick(2);
    exp_rd("ro_count", c_off_count, 32'd0);
    exp_rd("ro_offc",  2'd3,        32'd0);
    exp_rd("ro_ctrl",  c_off_ctrl,  32'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
